adc_demux: RTL and testbench

ADC_DEMUX -- requirements
Module: adc_demux

---
 rtl/adc_demux_pkg.sv | 21 ++
 rtl/adc_demux_lane.sv | 113 +++++++++++
 rtl/adc_demux.sv | 119 +++++++++++
 tb/tb_adc_demux.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_demux_pkg.sv
// ----------------------------------------------------------------------------
// adc_pkg
//   Shared types and constants for the ADC stream demultiplexer.
//   - lane_state_t : per-lane framing state (IDLE between frames, FRAME inside)
//   - DW_DEF/CW_DEF: default sample-data and counter widths
//   - ROUTE_CH0/1  : encoding of the latched destination of a lane
// ----------------------------------------------------------------------------
package adc_pkg;

    localparam int DW_DEF = 16;
    localparam int CW_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } lane_state_t;

    localparam logic ROUTE_CH0 = 1'b0;
    localparam logic ROUTE_CH1 = 1'b1;

endpackage

// File: rtl/adc_demux_lane.sv
// ----------------------------------------------------------------------------
// adc_demux_lane
//   One lane of the demultiplexer: frames the incoming sop/eop stream, latches
//   the destination at each sop and forwards every accepted beat, registered,
//   to exactly one of two destinations. Protocol errors (sop without a prior
//   eop, or a beat outside a frame) are counted.
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   sel                      : synchronized route select (sampled only at sop)
//   data/sop/eop/valid       : input beat
//   ch0_* / ch1_*            : registered output beat toward destination 0 / 1
//   err_cnt                  : wrapping protocol-error counter
// ----------------------------------------------------------------------------
module adc_demux_lane
    import adc_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel,
    input  logic [DW-1:0] data,
    input  logic          sop,
    input  logic          eop,
    input  logic          valid,
    output logic [DW-1:0] ch0_data,
    output logic          ch0_sop,
    output logic          ch0_eop,
    output logic          ch0_valid,
    output logic [DW-1:0] ch1_data,
    output logic          ch1_sop,
    output logic          ch1_eop,
    output logic          ch1_valid,
    output logic [CW-1:0] err_cnt
);

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    lane_state_t state, state_nxt;
    logic        route, route_nxt;
    logic        fwd;
    logic        err;
    logic        to_ch0;
    logic        to_ch1;

    // NOTE: every signal driven here gets a default first so no path through
    // the if/else tree leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        route_nxt = route;
        fwd       = 1'b0;
        err       = 1'b0;
        if (valid) begin
            if (sop) begin
                // A sop always opens a new frame; inside a frame it also means
                // the previous frame lost its eop.
                fwd       = 1'b1;
                route_nxt = sel;
                err       = (state == FRAME);
                state_nxt = eop ? IDLE : FRAME;
            end else if (state == FRAME) begin
                fwd       = 1'b1;
                state_nxt = eop ? IDLE : FRAME;
            end else begin
                // Beat outside any frame (including a stray eop): dropped.
                err = 1'b1;
            end
        end
    end

    assign to_ch0 = fwd && (route_nxt == ROUTE_CH0);
    assign to_ch1 = fwd && (route_nxt == ROUTE_CH1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            route <= ROUTE_CH0;
        end else begin
            state <= state_nxt;
            route <= route_nxt;
        end
    end

    // Output registers: the non-selected destination gets zero strobes while
    // its data register keeps the last beat it carried.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch0_data  <= '0;
            ch0_sop   <= 1'b0;
            ch0_eop   <= 1'b0;
            ch0_valid <= 1'b0;
            ch1_data  <= '0;
            ch1_sop   <= 1'b0;
            ch1_eop   <= 1'b0;
            ch1_valid <= 1'b0;
            err_cnt   <= '0;
        end else begin
            ch0_valid <= to_ch0;
            ch0_sop   <= to_ch0 & sop;
            ch0_eop   <= to_ch0 & eop;
            ch1_valid <= to_ch1;
            ch1_sop   <= to_ch1 & sop;
            ch1_eop   <= to_ch1 & eop;
            if (to_ch0) ch0_data <= data;
            if (to_ch1) ch1_data <= data;
            if (err)    err_cnt  <= err_cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/adc_demux.sv
// ----------------------------------------------------------------------------
// adc_demux
//   Two-lane ADC stream demultiplexer. A route select, asynchronous to clk,
//   is synchronized and applied per lane at frame boundaries only, so no frame
//   is ever split between destinations. Lanes route independently.
// Ports
//   clk, rst                       : clock, asynchronous active-high reset
//   adc_demux_s                    : async route select (0 -> ch0, 1 -> ch1)
//   adc_data_*_cha / _chb          : lane A / lane B input streams
//   adc_ch{0,1}_*_cha / _chb       : lane A / lane B outputs per destination
//   frame_cnt_ch0 / frame_cnt_ch1  : completed lane A frames per destination
//   err_cnt_cha / err_cnt_chb      : protocol errors per lane
// ----------------------------------------------------------------------------
module adc_demux
    import adc_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adc_demux_s,
    input  logic [DW-1:0] adc_data_cha,
    input  logic          adc_data_sop_cha,
    input  logic          adc_data_eop_cha,
    input  logic          adc_data_valid_cha,
    input  logic [DW-1:0] adc_data_chb,
    input  logic          adc_data_sop_chb,
    input  logic          adc_data_eop_chb,
    input  logic          adc_data_valid_chb,
    output logic [DW-1:0] adc_ch0_data_cha,
    output logic          adc_ch0_sop_cha,
    output logic          adc_ch0_eop_cha,
    output logic          adc_ch0_valid_cha,
    output logic [DW-1:0] adc_ch1_data_cha,
    output logic          adc_ch1_sop_cha,
    output logic          adc_ch1_eop_cha,
    output logic          adc_ch1_valid_cha,
    output logic [DW-1:0] adc_ch0_data_chb,
    output logic          adc_ch0_sop_chb,
    output logic          adc_ch0_eop_chb,
    output logic          adc_ch0_valid_chb,
    output logic [DW-1:0] adc_ch1_data_chb,
    output logic          adc_ch1_sop_chb,
    output logic          adc_ch1_eop_chb,
    output logic          adc_ch1_valid_chb,
    output logic [CW-1:0] frame_cnt_ch0,
    output logic [CW-1:0] frame_cnt_ch1,
    output logic [CW-1:0] err_cnt_cha,
    output logic [CW-1:0] err_cnt_chb
);

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic sel_meta;
    logic sel_sync;

    // Two-flop synchronizer for the asynchronous route select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_meta <= 1'b0;
            sel_sync <= 1'b0;
        end else begin
            sel_meta <= adc_demux_s;
            sel_sync <= sel_meta;
        end
    end

    adc_demux_lane #(.DW(DW), .CW(CW)) u_lane_a (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel_sync),
        .data      (adc_data_cha),
        .sop       (adc_data_sop_cha),
        .eop       (adc_data_eop_cha),
        .valid     (adc_data_valid_cha),
        .ch0_data  (adc_ch0_data_cha),
        .ch0_sop   (adc_ch0_sop_cha),
        .ch0_eop   (adc_ch0_eop_cha),
        .ch0_valid (adc_ch0_valid_cha),
        .ch1_data  (adc_ch1_data_cha),
        .ch1_sop   (adc_ch1_sop_cha),
        .ch1_eop   (adc_ch1_eop_cha),
        .ch1_valid (adc_ch1_valid_cha),
        .err_cnt   (err_cnt_cha)
    );

    adc_demux_lane #(.DW(DW), .CW(CW)) u_lane_b (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel_sync),
        .data      (adc_data_chb),
        .sop       (adc_data_sop_chb),
        .eop       (adc_data_eop_chb),
        .valid     (adc_data_valid_chb),
        .ch0_data  (adc_ch0_data_chb),
        .ch0_sop   (adc_ch0_sop_chb),
        .ch0_eop   (adc_ch0_eop_chb),
        .ch0_valid (adc_ch0_valid_chb),
        .ch1_data  (adc_ch1_data_chb),
        .ch1_sop   (adc_ch1_sop_chb),
        .ch1_eop   (adc_ch1_eop_chb),
        .ch1_valid (adc_ch1_valid_chb),
        .err_cnt   (err_cnt_chb)
    );

    // Frames are counted from the registered lane A outputs, so a frame counts
    // only once its eop has actually been presented to that destination.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_ch0 <= '0;
            frame_cnt_ch1 <= '0;
        end else begin
            if (adc_ch0_valid_cha && adc_ch0_eop_cha) frame_cnt_ch0 <= frame_cnt_ch0 + CNT_ONE;
            if (adc_ch1_valid_cha && adc_ch1_eop_cha) frame_cnt_ch1 <= frame_cnt_ch1 + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_adc_demux.sv
// ----------------------------------------------------------------------------
// tb_adc_demux
//   Directed scoreboard bench for adc_demux. Stimulus tasks push the expected
//   output beat (data, sop, eop, arrival cycle) into one queue per output port;
//   a negedge monitor pops and compares whenever a port shows valid.
//   Port index: 0 = ch0/lane A, 1 = ch1/lane A, 2 = ch0/lane B, 3 = ch1/lane B.
// ----------------------------------------------------------------------------
module tb_adc_demux;

    localparam int DW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          adc_demux_s = 1'b0;
    logic [DW-1:0] adc_data_cha = '0;
    logic          adc_data_sop_cha = 1'b0;
    logic          adc_data_eop_cha = 1'b0;
    logic          adc_data_valid_cha = 1'b0;
    logic [DW-1:0] adc_data_chb = '0;
    logic          adc_data_sop_chb = 1'b0;
    logic          adc_data_eop_chb = 1'b0;
    logic          adc_data_valid_chb = 1'b0;
    logic [DW-1:0] adc_ch0_data_cha, adc_ch1_data_cha, adc_ch0_data_chb, adc_ch1_data_chb;
    logic          adc_ch0_sop_cha, adc_ch1_sop_cha, adc_ch0_sop_chb, adc_ch1_sop_chb;
    logic          adc_ch0_eop_cha, adc_ch1_eop_cha, adc_ch0_eop_chb, adc_ch1_eop_chb;
    logic          adc_ch0_valid_cha, adc_ch1_valid_cha, adc_ch0_valid_chb, adc_ch1_valid_chb;
    logic [CW-1:0] frame_cnt_ch0, frame_cnt_ch1, err_cnt_cha, err_cnt_chb;

    adc_demux #(.DW(DW), .CW(CW)) dut (
        .clk                (clk),
        .rst                (rst),
        .adc_demux_s        (adc_demux_s),
        .adc_data_cha       (adc_data_cha),
        .adc_data_sop_cha   (adc_data_sop_cha),
        .adc_data_eop_cha   (adc_data_eop_cha),
        .adc_data_valid_cha (adc_data_valid_cha),
        .adc_data_chb       (adc_data_chb),
        .adc_data_sop_chb   (adc_data_sop_chb),
        .adc_data_eop_chb   (adc_data_eop_chb),
        .adc_data_valid_chb (adc_data_valid_chb),
        .adc_ch0_data_cha   (adc_ch0_data_cha),
        .adc_ch0_sop_cha    (adc_ch0_sop_cha),
        .adc_ch0_eop_cha    (adc_ch0_eop_cha),
        .adc_ch0_valid_cha  (adc_ch0_valid_cha),
        .adc_ch1_data_cha   (adc_ch1_data_cha),
        .adc_ch1_sop_cha    (adc_ch1_sop_cha),
        .adc_ch1_eop_cha    (adc_ch1_eop_cha),
        .adc_ch1_valid_cha  (adc_ch1_valid_cha),
        .adc_ch0_data_chb   (adc_ch0_data_chb),
        .adc_ch0_sop_chb    (adc_ch0_sop_chb),
        .adc_ch0_eop_chb    (adc_ch0_eop_chb),
        .adc_ch0_valid_chb  (adc_ch0_valid_chb),
        .adc_ch1_data_chb   (adc_ch1_data_chb),
        .adc_ch1_sop_chb    (adc_ch1_sop_chb),
        .adc_ch1_eop_chb    (adc_ch1_eop_chb),
        .adc_ch1_valid_chb  (adc_ch1_valid_chb),
        .frame_cnt_ch0      (frame_cnt_ch0),
        .frame_cnt_ch1      (frame_cnt_ch1),
        .err_cnt_cha        (err_cnt_cha),
        .err_cnt_chb        (err_cnt_chb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        int            cyc;
    } exp_t;

    exp_t  q[4][$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    string port_name[4] = '{"a0", "a1", "b0", "b1"};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares each presented beat against the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            logic          mv[4];
            logic [DW-1:0] md[4];
            logic          ms[4];
            logic          me[4];
            mv = '{adc_ch0_valid_cha, adc_ch1_valid_cha, adc_ch0_valid_chb, adc_ch1_valid_chb};
            md = '{adc_ch0_data_cha,  adc_ch1_data_cha,  adc_ch0_data_chb,  adc_ch1_data_chb};
            ms = '{adc_ch0_sop_cha,   adc_ch1_sop_cha,   adc_ch0_sop_chb,   adc_ch1_sop_chb};
            me = '{adc_ch0_eop_cha,   adc_ch1_eop_cha,   adc_ch0_eop_chb,   adc_ch1_eop_chb};
            for (int p = 0; p < 4; p++) begin
                if (mv[p]) begin
                    if (q[p].size() == 0) begin
                        check({"spurious_valid_", port_name[p]}, 32'(mv[p]), 32'd0);
                    end else begin
                        exp_t e;
                        e = q[p].pop_front();
                        check({"data_", port_name[p]}, 32'(md[p]), 32'(e.data));
                        check({"sop_",  port_name[p]}, 32'(ms[p]), 32'(e.sop));
                        check({"eop_",  port_name[p]}, 32'(me[p]), 32'(e.eop));
                        check({"cycle_", port_name[p]}, 32'(cyc), 32'(e.cyc));
                    end
                end else begin
                    // Strobes of an idle port must all be low.
                    check({"idle_strobes_", port_name[p]}, 32'({ms[p], me[p]}), 32'd0);
                end
            end
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    // dst: 0/1 = expected destination, -1 = expected to be dropped.
    task automatic beat(input logic va, input logic [DW-1:0] da, input logic sa, input logic ea, input int dsta,
                        input logic vb, input logic [DW-1:0] db, input logic sb, input logic eb, input int dstb);
        adc_data_valid_cha = va; adc_data_cha = da; adc_data_sop_cha = sa; adc_data_eop_cha = ea;
        adc_data_valid_chb = vb; adc_data_chb = db; adc_data_sop_chb = sb; adc_data_eop_chb = eb;
        if (va && dsta >= 0) q[dsta].push_back('{da, sa, ea, cyc + 1});
        if (vb && dstb >= 0) q[2 + dstb].push_back('{db, sb, eb, cyc + 1});
        @(posedge clk);
        #1;
    endtask

    task automatic beat_a(input logic [DW-1:0] d, input logic s, input logic e, input int dst);
        beat(1'b1, d, s, e, dst, 1'b0, '0, 1'b0, 1'b0, -1);
    endtask

    task automatic beat_b(input logic [DW-1:0] d, input logic s, input logic e, input int dst);
        beat(1'b0, '0, 1'b0, 1'b0, -1, 1'b1, d, s, e, dst);
    endtask

    task automatic idle(input int n);
        adc_data_valid_cha = 1'b0;
        adc_data_valid_chb = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_counters(input string tag, input int f0, input int f1, input int ea, input int eb);
        check({tag, "_frame_cnt_ch0"}, 32'(frame_cnt_ch0), 32'(f0));
        check({tag, "_frame_cnt_ch1"}, 32'(frame_cnt_ch1), 32'(f1));
        check({tag, "_err_cnt_cha"},   32'(err_cnt_cha),   32'(ea));
        check({tag, "_err_cnt_chb"},   32'(err_cnt_chb),   32'(eb));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valids"}, 32'({adc_ch0_valid_cha, adc_ch1_valid_cha, adc_ch0_valid_chb, adc_ch1_valid_chb}), 32'd0);
        check({tag, "_data"},   32'({adc_ch0_data_cha | adc_ch1_data_cha | adc_ch0_data_chb | adc_ch1_data_chb}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        check_counters("reset", 0, 0, 0, 0);
        rst = 1'b0;
        idle(3);

        // 8-beat lane A frame, sel=0 -> ch0
        for (int i = 1; i <= 8; i++) beat_a(DW'(i), i == 1, i == 8, 0);
        idle(2);
        check_counters("t1", 1, 0, 0, 0);

        // sel flips during a 16-beat frame: frame stays on ch0, next goes to ch1
        for (int i = 1; i <= 16; i++) begin
            if (i == 3) adc_demux_s = 1'b1;
            beat_a(DW'(16'h0100 + i), i == 1, i == 16, 0);
        end
        for (int i = 1; i <= 4; i++) beat_a(DW'(16'h0200 + i), i == 1, i == 4, 1);
        idle(2);
        check_counters("t2", 2, 1, 0, 0);
        check("t2_ch0_data_hold", 32'(adc_ch0_data_cha), 32'h0110);

        // Missing eop: sop, 3 beats, sop, 2 beats (last with eop)
        adc_demux_s = 1'b0;
        idle(3);
        beat_a(16'h0301, 1'b1, 1'b0, 0);
        beat_a(16'h0302, 1'b0, 1'b0, 0);
        beat_a(16'h0303, 1'b0, 1'b0, 0);
        beat_a(16'h0304, 1'b0, 1'b0, 0);
        beat_a(16'h0305, 1'b1, 1'b0, 0);
        beat_a(16'h0306, 1'b0, 1'b0, 0);
        beat_a(16'h0307, 1'b0, 1'b1, 0);
        idle(2);
        check_counters("t3", 3, 1, 1, 0);

        // Lane B beats outside a frame are dropped
        beat_b(16'h0401, 1'b0, 1'b0, -1);
        beat_b(16'h0402, 1'b0, 1'b1, -1);
        idle(2);
        check_counters("t4", 3, 1, 1, 2);

        // Single-beat frame on lane A toward ch1
        adc_demux_s = 1'b1;
        idle(3);
        beat_a(16'h0501, 1'b1, 1'b1, 1);
        idle(2);
        check_counters("t5", 3, 2, 1, 2);

        // Lanes routed to different destinations concurrently
        beat_b(16'h0601, 1'b1, 1'b0, 1);
        beat_b(16'h0602, 1'b0, 1'b0, 1);
        adc_demux_s = 1'b0;
        beat_b(16'h0603, 1'b0, 1'b0, 1);
        beat_b(16'h0604, 1'b0, 1'b0, 1);
        beat(1'b1, 16'h0701, 1'b1, 1'b0, 0, 1'b1, 16'h0605, 1'b0, 1'b0, 1);
        beat(1'b1, 16'h0702, 1'b0, 1'b1, 0, 1'b1, 16'h0606, 1'b0, 1'b1, 1);
        idle(2);
        check_counters("t6", 4, 2, 1, 2);

        // Reset mid-frame
        beat_a(16'h0801, 1'b1, 1'b0, 0);
        beat_a(16'h0802, 1'b0, 1'b0, 0);
        beat_a(16'h0803, 1'b0, 1'b0, 0);
        adc_data_valid_cha = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_quiet("t7_rst");
        check_counters("t7_rst", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        beat_a(16'h0804, 1'b0, 1'b0, -1);
        beat_a(16'h0805, 1'b0, 1'b1, -1);
        beat_a(16'h0901, 1'b1, 1'b0, 0);
        beat_a(16'h0902, 1'b0, 1'b1, 0);
        idle(2);
        check_counters("t7", 1, 0, 2, 0);

        idle(2);
        for (int p = 0; p < 4; p++) check({"pending_", port_name[p]}, 32'(q[p].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
